// File: rtl/section_decision.sv
// Razor-protected a-posteriori decision section: replays errored cycles, forces acceptance
// after MAX_RETRY consecutive errors, and hands one llr_post/hard_bit result to the consumer.
module section_decision #(
    parameter int unsigned N         = 6,
    parameter int unsigned M         = 6,
    parameter int unsigned ITER      = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                Start,
    input  logic signed [M-1:0] be1_DFF,
    input  logic                Error_current_Section,
    input  logic signed [N-1:0] ba1,
    input  logic signed [N-1:0] ba2,
    input  logic                Ack,
    output logic signed [M+1:0] llr_post,
    output logic                hard_bit,
    output logic                Valid,
    output logic                Busy,
    output logic                Degraded,
    output logic [7:0]          error_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              r_state;
    logic [7:0]          r_iter;
    logic [3:0]          r_retry;
    logic signed [M-1:0] r_be1_hold;
    logic signed [M+1:0] r_llr_post;
    logic                r_hard_bit;
    logic                r_valid;
    logic                r_degraded;
    logic [7:0]          r_error_count;

    logic                w_forced;
    logic                w_last_iter;
    logic [7:0]          w_err_inc;
    logic signed [M+1:0] w_sum;

    // The final accepted be1_DFF is the value entering be1_hold on the completing edge.
    assign w_sum = {{(M+2-N){ba1[N-1]}}, ba1} + {{(M+2-N){ba2[N-1]}}, ba2}
                 + {{2{be1_DFF[M-1]}}, be1_DFF};

    assign w_forced    = (r_retry == 4'(MAX_RETRY - 1));
    assign w_last_iter = (r_iter == 8'(ITER - 1));
    assign w_err_inc   = (r_error_count == 8'hFF) ? r_error_count : r_error_count + 8'd1;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state       <= StIdle;
            r_iter        <= '0;
            r_retry       <= '0;
            r_be1_hold    <= '0;
            r_llr_post    <= '0;
            r_hard_bit    <= 1'b0;
            r_valid       <= 1'b0;
            r_degraded    <= 1'b0;
            r_error_count <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_state       <= StRun;
                        r_iter        <= '0;
                        r_retry       <= '0;
                        r_be1_hold    <= '0;
                        r_degraded    <= 1'b0;
                        r_error_count <= '0;
                    end
                end
                StRun: begin
                    if (Error_current_Section && !w_forced) begin
                        r_retry       <= r_retry + 4'd1;
                        r_error_count <= w_err_inc;
                    end else begin
                        if (Error_current_Section) begin
                            r_degraded    <= 1'b1;
                            r_error_count <= w_err_inc;
                        end
                        r_be1_hold <= be1_DFF;
                        r_retry    <= '0;
                        r_iter     <= r_iter + 8'd1;
                        if (w_last_iter) begin
                            r_state    <= StDone;
                            r_valid    <= 1'b1;
                            r_llr_post <= w_sum;
                            r_hard_bit <= w_sum[M+1];
                        end
                    end
                end
                StDone: begin
                    if (Ack) begin
                        r_state <= StIdle;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign llr_post    = r_llr_post;
    assign hard_bit    = r_hard_bit;
    assign Valid       = r_valid;
    assign Busy        = (r_state == StRun);
    assign Degraded    = r_degraded;
    assign error_count = r_error_count;

endmodule

// File: tb/tb_section_decision.sv
// Self-checking bench for section_decision: directed scenarios plus randomized blocks
// compared against a behavioural model of the accept/replay/force rules.
module tb_section_decision;

    localparam int N         = 6;
    localparam int M         = 6;
    localparam int ITER      = 8;
    localparam int MAX_RETRY = 3;

    logic                Clock;
    logic                nReset;
    logic                Start;
    logic signed [M-1:0] be1_DFF;
    logic                Error_current_Section;
    logic signed [N-1:0] ba1;
    logic signed [N-1:0] ba2;
    logic                Ack;
    logic signed [M+1:0] llr_post;
    logic                hard_bit;
    logic                Valid;
    logic                Busy;
    logic                Degraded;
    logic [7:0]          error_count;

    int n_checks = 0;
    int n_fail   = 0;

    bit err_pat[$];
    int exp_llr;
    bit exp_hard;
    bit exp_deg;
    int exp_ec;

    section_decision #(
        .N(N), .M(M), .ITER(ITER), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .Clock                 (Clock),
        .nReset                (nReset),
        .Start                 (Start),
        .be1_DFF               (be1_DFF),
        .Error_current_Section (Error_current_Section),
        .ba1                   (ba1),
        .ba2                   (ba2),
        .Ack                   (Ack),
        .llr_post              (llr_post),
        .hard_bit              (hard_bit),
        .Valid                 (Valid),
        .Busy                  (Busy),
        .Degraded              (Degraded),
        .error_count           (error_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({Valid, Busy, hard_bit, Degraded} !== 4'b0 || llr_post !== '0 || error_count !== 8'd0)
        begin
            n_fail++;
            $display("FAIL %s: Valid=%0b Busy=%0b hard=%0b Deg=%0b llr=%0d ec=%0d, required all 0",
                     name, Valid, Busy, hard_bit, Degraded, llr_post, error_count);
        end
    endtask

    // Drives one block from Start to Valid; the model tracks accepts, replays and forces.
    task automatic run_block(input int a1, input int a2, input bit rand_be1, input int be1c,
                             input bit noisy, input string name);
        int edges = 0;
        int idx = 0;
        int acc = 0;
        int consec = 0;
        int errs = 0;
        int replays = 0;
        int held = 0;
        int cur_be1;
        bit e;
        ba1 = a1[N-1:0];
        ba2 = a2[N-1:0];
        Error_current_Section = 1'b0;
        Ack = 1'b0;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        edges = 1;
        while (!Valid && edges < 300) begin
            cur_be1 = rand_be1 ? int'($urandom_range(0, 63)) - 32 : be1c;
            e = (idx < err_pat.size()) ? err_pat[idx] : 1'b0;
            be1_DFF = cur_be1[M-1:0];
            Error_current_Section = e;
            if (noisy) begin
                Start = 1'($urandom);
                Ack   = 1'($urandom);
            end
            @(negedge Clock);
            edges++;
            idx++;
            if (!e) begin
                acc++;
                consec = 0;
                held = cur_be1;
            end else begin
                errs++;
                consec++;
                if (consec == MAX_RETRY) begin
                    acc++;
                    consec = 0;
                    exp_deg = 1'b1;
                    held = cur_be1;
                end else begin
                    replays++;
                end
            end
            n_checks++;
            if (int'(dut.r_be1_hold) !== held) begin
                n_fail++;
                $display("FAIL %s be1_hold cycle %0d: got %0d, required %0d",
                         name, idx, dut.r_be1_hold, held);
            end
        end
        Start = 1'b0;
        Ack = 1'b0;
        Error_current_Section = 1'b0;
        exp_llr  = a1 + a2 + held;
        exp_hard = (exp_llr < 0);
        exp_ec   = (errs > 255) ? 255 : errs;
        n_checks++;
        if (!Valid || edges != ITER + replays + 1) begin
            n_fail++;
            $display("FAIL %s latency: Valid=%0b after %0d edges, required 1 after %0d",
                     name, Valid, edges, ITER + replays + 1);
        end
        n_checks++;
        if (int'(llr_post) !== exp_llr || hard_bit !== exp_hard) begin
            n_fail++;
            $display("FAIL %s result: llr=%0d hard=%0b, required llr=%0d hard=%0b",
                     name, llr_post, hard_bit, exp_llr, exp_hard);
        end
        n_checks++;
        if (Degraded !== exp_deg || int'(error_count) !== exp_ec || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s status: Deg=%0b ec=%0d Busy=%0b, required Deg=%0b ec=%0d Busy=0",
                     name, Degraded, error_count, Busy, exp_deg, exp_ec);
        end
    endtask

    task automatic finish_block(input bit start_too, input string name);
        Start = start_too;
        Ack = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Ack = 1'b0;
        n_checks++;
        if (Valid !== 1'b0 || Busy !== 1'b0 || int'(llr_post) !== exp_llr
            || Degraded !== exp_deg || int'(error_count) !== exp_ec) begin
            n_fail++;
            $display("FAIL %s ack: Valid=%0b Busy=%0b llr=%0d Deg=%0b ec=%0d, required 0 0 %0d %0b %0d",
                     name, Valid, Busy, llr_post, Degraded, error_count, exp_llr, exp_deg, exp_ec);
        end
        @(negedge Clock);
        n_checks++;
        if (Busy !== 1'b0 || Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: Busy=%0b Valid=%0b, required 0 0", name, Busy, Valid);
        end
    endtask

    task automatic new_block(input bit errs[$]);
        err_pat = errs;
        exp_deg = 1'b0;
    endtask

    task automatic test_reset();
        check_all_zero("reset");
    endtask

    task automatic test_nominal();
        new_block('{});
        run_block(5, -3, 1'b0, -10, 1'b0, "nominal");
        finish_block(1'b0, "nominal");
    endtask

    task automatic test_isolated_errors();
        new_block('{0, 0, 0, 1, 0, 0, 1, 0});
        run_block(7, 2, 1'b1, 0, 1'b0, "isolated");
        finish_block(1'b0, "isolated");
    endtask

    task automatic test_forced();
        new_block('{1, 1, 1, 0});
        run_block(-4, 9, 1'b1, 0, 1'b0, "forced");
        finish_block(1'b0, "forced");
        new_block('{0, 1, 1, 1, 1, 1, 1, 0, 1, 1});
        run_block(3, -20, 1'b1, 0, 1'b0, "forced_twice");
        finish_block(1'b0, "forced_twice");
    endtask

    task automatic test_extremes();
        new_block('{});
        run_block(31, 31, 1'b0, 31, 1'b0, "max_pos");
        finish_block(1'b0, "max_pos");
        new_block('{});
        run_block(-32, -32, 1'b0, -32, 1'b0, "max_neg");
        finish_block(1'b0, "max_neg");
    endtask

    task automatic test_ack_hold();
        new_block('{0, 1, 0});
        run_block(-11, 6, 1'b1, 0, 1'b0, "ack_hold");
        for (int i = 0; i < 20; i++) begin
            Start = 1'($urandom);
            Error_current_Section = 1'($urandom);
            be1_DFF = M'($urandom);
            @(negedge Clock);
            n_checks++;
            if (Valid !== 1'b1 || Busy !== 1'b0 || int'(llr_post) !== exp_llr
                || hard_bit !== exp_hard || Degraded !== exp_deg
                || int'(error_count) !== exp_ec) begin
                n_fail++;
                $display("FAIL ack_hold cycle %0d: Valid=%0b Busy=%0b llr=%0d ec=%0d, required 1 0 %0d %0d",
                         i, Valid, Busy, llr_post, error_count, exp_llr, exp_ec);
            end
        end
        Error_current_Section = 1'b0;
        finish_block(1'b1, "ack_with_start");
    endtask

    task automatic test_reset_mid_run();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Error_current_Section = 1'b1;
        @(negedge Clock);
        Error_current_Section = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 0; i < ITER + 4; i++) begin
            @(negedge Clock);
            n_checks++;
            if (Valid !== 1'b0 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: Valid=%0b Busy=%0b, required 0 0",
                         i, Valid, Busy);
            end
        end
        new_block('{});
        run_block(12, -25, 1'b1, 0, 1'b0, "after_reset");
        finish_block(1'b0, "after_reset");
    endtask

    task automatic test_random();
        bit pat[$];
        for (int b = 0; b < 12; b++) begin
            pat = {};
            for (int i = 0; i < 30; i++) pat.push_back($urandom_range(0, 2) == 0);
            new_block(pat);
            run_block(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                      1'b1, 0, 1'b1, $sformatf("random%0d", b));
            finish_block(1'($urandom), $sformatf("random%0d", b));
        end
    endtask

    initial begin
        nReset = 1'b0;
        Start = 1'b0;
        Ack = 1'b0;
        Error_current_Section = 1'b0;
        be1_DFF = '0;
        ba1 = '0;
        ba2 = '0;
        repeat (3) @(negedge Clock);
        test_reset();
        nReset = 1'b1;
        test_nominal();
        test_isolated_errors();
        test_forced();
        test_extremes();
        test_ack_hold();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
